rsa_core_arbiter: RTL and testbench



---
 rtl/rsa_core_arbiter.sv | 133 +++++++++++++
 tb/tb_rsa_core_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_core_arbiter.sv
// rsa_core_arbiter: shares a single Rsa256Core modular-exponentiation engine
// among NREQ requesters. A round-robin pointer picks the next requester in
// IDLE, its operands are frozen into the core operand registers, and the
// core's src/result handshakes are sequenced before the result is handed
// back to the requester that owns the job. Only one job is in flight.
//
// Handshake semantics: on the core side (src_val/src_rdy, result_val/
// result_rdy) and on the response side (resp_val/resp_rdy) a transfer takes
// place on a rising i_clk edge where valid and ready are both high; valid,
// once raised, is held with stable data until that edge. req_rdy is a
// one-cycle acknowledge that the owner's operands were captured at the
// previous edge, so the requester may drop req_val or change its operands.
module rsa_core_arbiter #(
  parameter  int NREQ = 2,
  parameter  int W    = 256,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] req_val,
  output logic [NREQ-1:0] req_rdy,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_e,
  input  logic [NREQ*W-1:0] req_n,
  output logic [NREQ-1:0] resp_val,
  input  logic [NREQ-1:0] resp_rdy,
  output logic [W-1:0]    resp_data,
  output logic            busy,
  output logic [IW-1:0]   owner,
  output logic            core_src_val,
  input  logic            core_src_rdy,
  output logic [W-1:0]    core_a,
  output logic [W-1:0]    core_e,
  output logic [W-1:0]    core_n,
  input  logic            core_result_val,
  output logic            core_result_rdy,
  input  logic [W-1:0]    core_result,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   cand;
  logic            grant_found;

  // Round-robin pick: first pending requester at or after ptr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!grant_found && req_val[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state logic; core_result_rdy is the registered one-cycle accept,
  // so WAIT leaves exactly one cycle after it was raised.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (grant_found) state_d = S_ISSUE;
      S_ISSUE:   if (core_src_rdy) state_d = S_WAIT;
      S_WAIT:    if (core_result_rdy) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (resp_rdy[owner]) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded directly from the current state.
  always_comb begin
    core_src_val = (state_q == S_ISSUE);
    busy         = (state_q != S_IDLE);
    resp_val     = (state_q == S_RESP) ? (NREQ'(1) << owner) : '0;
    dbg_state    = state_q;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant capture, result-accept pulse and result latch. Operands stay
  // frozen for the whole job because the core samples them a cycle late.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q           <= '0;
      owner           <= '0;
      req_rdy         <= '0;
      core_result_rdy <= 1'b0;
      resp_data       <= '0;
      core_a          <= '0;
      core_e          <= '0;
      core_n          <= '0;
    end else begin
      req_rdy         <= '0;
      core_result_rdy <= 1'b0;
      if (state_q == S_IDLE && grant_found) begin
        owner   <= grant_idx;
        ptr_q   <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IW'(1);
        core_a  <= req_a[int'(grant_idx)*W +: W];
        core_e  <= req_e[int'(grant_idx)*W +: W];
        core_n  <= req_n[int'(grant_idx)*W +: W];
        req_rdy <= NREQ'(1) << grant_idx;
      end
      if (state_q == S_WAIT && !core_result_rdy && core_result_val) begin
        core_result_rdy <= 1'b1;
      end
      if (state_q == S_CAPTURE) begin
        resp_data <= core_result;
      end
    end
  end

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Testbench for rsa_core_arbiter with four requesters and a behavioural
// Rsa256Core stand-in that randomises its handshake timing.
module tb_rsa_core_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 256;
  localparam int IW   = 2;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NREQ-1:0]   req_val;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_e;
  logic [NREQ*W-1:0] req_n;
  logic [NREQ-1:0]   resp_val;
  logic [NREQ-1:0]   resp_rdy;
  logic [W-1:0]      resp_data;
  logic              busy;
  logic [IW-1:0]     owner;
  logic              core_src_val;
  logic              core_src_rdy;
  logic [W-1:0]      core_a;
  logic [W-1:0]      core_e;
  logic [W-1:0]      core_n;
  logic              core_result_val;
  logic              core_result_rdy;
  logic [W-1:0]      core_result;
  logic [2:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;
  logic [W-1:0]    exp_q[$];
  int              own_q[$];
  logic [NREQ-1:0] prev_req = '0;

  rsa_core_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_a(req_a), .req_e(req_e), .req_n(req_n),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .busy(busy), .owner(owner),
    .core_src_val(core_src_val), .core_src_rdy(core_src_rdy),
    .core_a(core_a), .core_e(core_e), .core_n(core_n),
    .core_result_val(core_result_val), .core_result_rdy(core_result_rdy),
    .core_result(core_result), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic longint unsigned modexp(longint unsigned a, longint unsigned e,
                                             longint unsigned n);
    longint unsigned r, b, x;
    r = 1 % n;
    b = a % n;
    x = e;
    while (x != 0) begin
      if (x[0]) r = (r * b) % n;
      b = (b * b) % n;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int rr_pick(int p, logic [NREQ-1:0] m);
    logic [NREQ-1:0] rot;
    rot = m;
    for (int i = 0; i < NREQ; i++) begin
      rot = m >> ((p + i) % NREQ);
      if (rot[0]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Expected grant for the request mask presented at the last edge; also
  // records the expected result and owner of that job.
  function automatic logic [NREQ-1:0] model_grant();
    int g;
    g = rr_pick(m_ptr, prev_req);
    if (g < 0) return '0;
    m_ptr = (g + 1) % NREQ;
    exp_q.push_back(W'(modexp(req_a[g*W +: 64], req_e[g*W +: 64], req_n[g*W +: 64])));
    own_q.push_back(g);
    return NREQ'(1) << g;
  endfunction

  // ---------------- behavioural core ----------------
  int cm_phase;
  int cm_cnt;
  always @(posedge i_clk) begin
    if (i_rst) begin
      cm_phase        <= 0;
      cm_cnt          <= 0;
      core_src_rdy    <= 1'b0;
      core_result_val <= 1'b0;
      core_result     <= '0;
    end else begin
      case (cm_phase)
        0: begin
          if (core_src_val && core_src_rdy) begin
            cm_phase     <= 1;
            cm_cnt       <= int'($urandom_range(1, 6));
            core_src_rdy <= 1'b0;
            core_result  <= {8{$urandom}};
          end else begin
            core_src_rdy <= 1'($urandom_range(0, 1));
          end
        end
        1: begin
          if (cm_cnt <= 1) begin
            cm_phase        <= 2;
            core_result_val <= 1'b1;
          end else begin
            cm_cnt <= cm_cnt - 1;
          end
        end
        2: begin
          if (core_result_rdy) begin
            cm_phase    <= 3;
            core_result <= W'(modexp(core_a[63:0], core_e[63:0], core_n[63:0]));
          end
        end
        default: begin
          core_result_val <= 1'b0;
          cm_phase        <= 0;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    prev_req = req_val;
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ops(int k, longint unsigned a, longint unsigned e, longint unsigned n);
    req_a[k*W +: W] = W'(a);
    req_e[k*W +: W] = W'(e);
    req_n[k*W +: W] = W'(n);
  endtask

  task automatic rand_ops(int k);
    set_ops(k, longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 1000)),
            longint'($urandom_range(2, 65535)));
  endtask

  task automatic do_reset();
    i_rst    = 1'b1;
    req_val  = '0;
    resp_rdy = '0;
    repeat (2) step();
    i_rst = 1'b0;
    m_ptr = 0;
    exp_q.delete();
    own_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst    = 1'b1;
    req_val  = '1;
    resp_rdy = '0;
    for (int k = 0; k < NREQ; k++) set_ops(k, 64'd9, 64'd9, 64'd9);
    repeat (2) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (req_rdy !== 4'b0) begin failures++; $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy); end
    checks++; if (resp_val !== 4'b0) begin failures++; $display("FAIL reset_resp_val: got %b expected 0000", resp_val); end
    checks++; if (core_src_val !== 1'b0) begin failures++; $display("FAIL reset_src_val: got %b expected 0", core_src_val); end
    checks++; if (core_result_rdy !== 1'b0) begin failures++; $display("FAIL reset_result_rdy: got %b expected 0", core_result_rdy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    checks++; if (resp_data !== '0) begin failures++; $display("FAIL reset_resp_data: got %0h expected 0", resp_data); end
    checks++; if ((core_a | core_e | core_n) !== '0) begin failures++; $display("FAIL reset_operands: got a=%0h e=%0h n=%0h expected 0", core_a, core_e, core_n); end
    do_reset();
  endtask

  task automatic test_single();
    int pulses;
    bit done;
    do_reset();
    set_ops(0, 64'd3, 64'd5, 64'd7);
    req_val  = 4'b0001;
    resp_rdy = 4'b1111;
    step();
    checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b expected 0001", req_rdy); end
    checks++; if (core_src_val !== 1'b1) begin failures++; $display("FAIL single_src_val: got %b expected 1", core_src_val); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy); end
    pulses  = (req_rdy[0] === 1'b1) ? 1 : 0;
    req_val = '0;
    done    = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      if (req_rdy != '0) pulses++;
      if (resp_val != '0) begin
        checks++; if (resp_val !== 4'b0001) begin failures++; $display("FAIL single_resp_val: got %b expected 0001", resp_val); end
        checks++; if (resp_data !== W'(5)) begin failures++; $display("FAIL single_resp_data: got %0d expected 5", resp_data); end
        done = 1'b1;
      end
    end
    checks++; if (!done) begin failures++; $display("FAIL single_timeout: got no response expected one"); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_simultaneous();
    int gi, got;
    int      exp_own[2];
    logic [W-1:0] exp_dat[2];
    exp_own = '{0, 1};
    exp_dat = '{W'(24), W'(5)};
    do_reset();
    set_ops(0, 64'd2, 64'd10, 64'd1000);
    set_ops(1, 64'd3, 64'd5, 64'd7);
    req_val  = 4'b0011;
    resp_rdy = 4'b1111;
    gi  = 0;
    got = 0;
    for (int c = 0; c < 400 && got < 2; c++) begin
      step();
      if (req_rdy != '0) begin
        checks++; if (gi >= 2 || req_rdy !== (4'(1) << exp_own[gi])) begin failures++; $display("FAIL simul_grant: got %b (grant %0d) expected one-hot of requester %0d", req_rdy, gi, exp_own[gi % 2]); end
        req_val = req_val & ~req_rdy;
        gi++;
      end
      if (resp_val != '0) begin
        checks++; if (resp_val !== (4'(1) << exp_own[got])) begin failures++; $display("FAIL simul_resp_val: got %b expected requester %0d", resp_val, exp_own[got]); end
        checks++; if (resp_data !== exp_dat[got]) begin failures++; $display("FAIL simul_resp_data: got %0d expected %0d", resp_data, exp_dat[got]); end
        checks++; if (owner !== 2'(exp_own[got])) begin failures++; $display("FAIL simul_owner: got %0d expected %0d", owner, exp_own[got]); end
        got++;
      end
    end
    checks++; if (got != 2) begin failures++; $display("FAIL simul_timeout: got %0d responses expected 2", got); end
  endtask

  task automatic test_fairness();
    int grants, done;
    logic [NREQ-1:0] gm;
    int order[8];
    order = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int k = 0; k < NREQ; k++) rand_ops(k);
    req_val  = '1;
    resp_rdy = '0;
    grants   = 0;
    done     = 0;
    for (int c = 0; c < 2000 && done < 8; c++) begin
      step();
      if (req_rdy != '0) begin
        gm = model_grant();
        checks++; if (req_rdy !== gm) begin failures++; $display("FAIL fair_grant_model: got %b expected %b", req_rdy, gm); end
        checks++; if (grants >= 8 || req_rdy !== (4'(1) << order[grants])) begin failures++; $display("FAIL fair_order: got %b at grant %0d", req_rdy, grants); end
        for (int k = 0; k < NREQ; k++) if (req_rdy[k]) rand_ops(k);
        grants++;
      end
      resp_rdy = 4'($urandom_range(0, 15));
      if ((resp_val & resp_rdy) != '0) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL fair_unexpected_resp: got %b expected none", resp_val);
        end else begin
          checks++; if (resp_val !== (4'(1) << own_q[0])) begin failures++; $display("FAIL fair_resp_val: got %b expected requester %0d", resp_val, own_q[0]); end
          checks++; if (resp_data !== exp_q[0]) begin failures++; $display("FAIL fair_resp_data: got %0h expected %0h", resp_data, exp_q[0]); end
          void'(exp_q.pop_front());
          void'(own_q.pop_front());
        end
        done++;
      end
    end
    req_val = '0;
    checks++; if (done != 8) begin failures++; $display("FAIL fair_timeout: got %0d responses expected 8", done); end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] gm, held_v;
    logic [W-1:0]    held_d;
    bit              seen;
    int              got;
    do_reset();
    rand_ops(2);
    req_val  = 4'b0100;
    resp_rdy = '0;
    seen     = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      if (req_rdy != '0) begin
        gm = model_grant();
        checks++; if (req_rdy !== gm) begin failures++; $display("FAIL bp_grant: got %b expected %b", req_rdy, gm); end
        req_val = req_val & ~req_rdy;
      end
      if (resp_val != '0) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL bp_timeout: got no response expected one"); end
    held_v   = resp_val;
    held_d   = resp_data;
    checks++; if (held_v !== 4'b0100) begin failures++; $display("FAIL bp_resp_val: got %b expected 0100", held_v); end
    checks++; if (exp_q.size() == 0 || held_d !== exp_q[0]) begin failures++; $display("FAIL bp_resp_data: got %0h expected model result", held_d); end
    rand_ops(3);
    req_val  = 4'b1000;
    resp_rdy = ~4'b0100;
    repeat (20) begin
      step();
      checks++; if (resp_val !== held_v || resp_data !== held_d) begin failures++; $display("FAIL bp_hold: got %b/%0h expected %b/%0h", resp_val, resp_data, held_v, held_d); end
      checks++; if (req_rdy !== 4'b0 || core_src_val !== 1'b0) begin failures++; $display("FAIL bp_quiet: got req_rdy=%b src_val=%b expected 0000/0", req_rdy, core_src_val); end
    end
    resp_rdy = 4'b0100;
    step();
    checks++; if (busy !== 1'b0 || resp_val !== 4'b0) begin failures++; $display("FAIL bp_release: got busy=%b resp_val=%b expected 0/0000", busy, resp_val); end
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      void'(own_q.pop_front());
    end
    resp_rdy = '1;
    got      = 0;
    for (int c = 0; c < 200 && got < 1; c++) begin
      step();
      if (req_rdy != '0) begin
        gm = model_grant();
        checks++; if (req_rdy !== gm) begin failures++; $display("FAIL bp_next_grant: got %b expected %b", req_rdy, gm); end
        req_val = req_val & ~req_rdy;
      end
      if (resp_val != '0) begin
        checks++; if (exp_q.size() == 0 || resp_val !== (4'(1) << own_q[0]) || resp_data !== exp_q[0]) begin failures++; $display("FAIL bp_next_resp: got %b/%0h expected model job", resp_val, resp_data); end
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(own_q.pop_front()); end
        got++;
      end
    end
    checks++; if (got != 1) begin failures++; $display("FAIL bp_next_timeout: got %0d responses expected 1", got); end
  endtask

  task automatic test_reset_mid_job();
    bit seen_issue, hit;
    int got;
    logic [NREQ-1:0] gm;
    exp_q.delete();
    own_q.delete();
    rand_ops(1);
    req_val    = 4'b0010;
    resp_rdy   = '1;
    seen_issue = 1'b0;
    hit        = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      step();
      if (req_rdy != '0) req_val = '0;
      if (core_src_val) seen_issue = 1'b1;
      else if (seen_issue && busy) hit = 1'b1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL mid_reach_wait: got no WAIT cycle expected one"); end
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    m_ptr = 0;
    checks++; if (busy !== 1'b0 || req_rdy !== 4'b0 || resp_val !== 4'b0) begin failures++; $display("FAIL mid_reset_ctrl: got busy=%b req_rdy=%b resp_val=%b expected zeros", busy, req_rdy, resp_val); end
    checks++; if (core_src_val !== 1'b0 || core_result_rdy !== 1'b0 || owner !== 2'd0) begin failures++; $display("FAIL mid_reset_core: got src_val=%b result_rdy=%b owner=%0d expected zeros", core_src_val, core_result_rdy, owner); end
    checks++; if (resp_data !== '0 || core_a !== '0 || core_e !== '0 || core_n !== '0) begin failures++; $display("FAIL mid_reset_data: got resp_data=%0h core_a=%0h expected 0", resp_data, core_a); end
    rand_ops(1);
    rand_ops(3);
    req_val = 4'b1010;
    got     = 0;
    for (int c = 0; c < 400 && got < 2; c++) begin
      step();
      if (req_rdy != '0) begin
        gm = model_grant();
        checks++; if (req_rdy !== gm) begin failures++; $display("FAIL mid_after_grant: got %b expected %b", req_rdy, gm); end
        req_val = req_val & ~req_rdy;
      end
      if (resp_val != '0) begin
        checks++; if (exp_q.size() == 0 || resp_val !== (4'(1) << own_q[0]) || resp_data !== exp_q[0]) begin failures++; $display("FAIL mid_after_resp: got %b/%0h expected model job", resp_val, resp_data); end
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(own_q.pop_front()); end
        got++;
      end
    end
    checks++; if (got != 2) begin failures++; $display("FAIL mid_after_timeout: got %0d responses expected 2", got); end
  endtask

  task automatic test_withdrawn();
    int pulsed, r1, got;
    logic [NREQ-1:0] gm;
    do_reset();
    rand_ops(0);
    rand_ops(1);
    req_val  = 4'b0001;
    resp_rdy = '1;
    pulsed   = 0;
    r1       = 0;
    got      = 0;
    for (int c = 0; c < 300 && got < 1; c++) begin
      step();
      if (req_rdy[1]) r1++;
      if (req_rdy != '0) begin
        gm = model_grant();
        checks++; if (req_rdy !== gm) begin failures++; $display("FAIL wd_grant: got %b expected %b", req_rdy, gm); end
        req_val = req_val & ~req_rdy;
      end
      if (pulsed == 1) begin
        req_val[1] = 1'b0;
        pulsed     = 2;
      end else if (pulsed == 0 && busy && !core_src_val && resp_val == '0) begin
        req_val[1] = 1'b1;
        pulsed     = 1;
      end
      if (resp_val != '0) begin
        checks++; if (exp_q.size() == 0 || resp_val !== (4'(1) << own_q[0]) || resp_data !== exp_q[0]) begin failures++; $display("FAIL wd_resp: got %b/%0h expected model job", resp_val, resp_data); end
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(own_q.pop_front()); end
        got++;
      end
    end
    repeat (10) begin
      step();
      if (req_rdy[1]) r1++;
    end
    checks++; if (got != 1) begin failures++; $display("FAIL wd_timeout: got %0d responses expected 1", got); end
    checks++; if (r1 != 0 || pulsed != 2) begin failures++; $display("FAIL wd_never_granted: got %0d grants to requester 1 (pulse state %0d) expected 0", r1, pulsed); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int done;
    logic [NREQ-1:0] gm;
    do_reset();
    for (int k = 0; k < NREQ; k++) rand_ops(k);
    done = 0;
    for (int c = 0; c < 3400; c++) begin
      step();
      if (req_rdy != '0) begin
        gm = model_grant();
        checks++; if (req_rdy !== gm) begin failures++; $display("FAIL b2b_grant: got %b expected %b (ptr %0d)", req_rdy, gm, m_ptr); end
        for (int k = 0; k < NREQ; k++) begin
          if (req_rdy[k]) begin
            if ($urandom_range(0, 1) == 0) req_val[k] = 1'b0;
            rand_ops(k);
          end
        end
      end
      if (c < 3000) begin
        for (int k = 0; k < NREQ; k++) begin
          if ($urandom_range(0, 7) == 0) begin
            req_val[k] = ~req_val[k];
            if (req_val[k]) rand_ops(k);
          end
        end
        resp_rdy = 4'($urandom_range(0, 15));
      end else begin
        req_val  = '0;
        resp_rdy = '1;
      end
      if ((resp_val & resp_rdy) != '0) begin
        checks++; if (exp_q.size() == 0 || resp_val !== (4'(1) << own_q[0]) || resp_data !== exp_q[0]) begin failures++; $display("FAIL b2b_resp: got %b/%0h expected model job", resp_val, resp_data); end
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(own_q.pop_front()); end
        done++;
      end
    end
    checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %0d outstanding busy=%b expected 0/0", exp_q.size(), busy); end
    checks++; if (done < 20) begin failures++; $display("FAIL b2b_throughput: got %0d jobs expected at least 20", done); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_rst    = 1'b1;
    req_val  = '0;
    resp_rdy = '0;
    req_a    = '0;
    req_e    = '0;
    req_n    = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_reset_mid_job();
    test_withdrawn();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
